sc_reg_shift_sink: RTL and testbench

- Writable datapath register that captures a value from the shared data bus. It is the sink counterpart of the constant-source fixed register.
- Adds a multi-cycle shift engine: one bit per clock, with a start/busy/done handshake, so the datapath controller can sequence shifts.
- Output drives the datapath bus back directly; the zero flag feeds the controller.

---
 rtl/sc_reg_shift_sink.sv | 129 ++++++++++++
 tb/tb_sc_reg_shift_sink.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_reg_shift_sink.sv
// Writable datapath register with a one-bit-per-clock shift engine (start/busy/done).
// Optional carry-out of the last shifted bit when SC_REGSINK_CARRY_EN is defined.
module sc_reg_shift_sink #(
  parameter int                       DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REG_INIT = '0,
  parameter int                       SHAMT_WIDTH   = 5
) (
  input  logic                     SC_RegFIXED_CLOCK_50,
  input  logic                     SC_RegFIXED_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegSINK_data_InBUS,
  input  logic                     SC_RegSINK_load_In,
  input  logic                     SC_RegSINK_clear_In,
  input  logic                     SC_RegSINK_start_In,
  input  logic                     SC_RegSINK_dir_In,
  input  logic                     SC_RegSINK_arith_In,
  input  logic [SHAMT_WIDTH-1:0]   SC_RegSINK_shamt_In,
  output logic [DATAWIDTH_BUS-1:0] SC_RegSINK_data_OutBUS,
  output logic                     SC_RegSINK_busy_Out,
  output logic                     SC_RegSINK_done_Out,
  output logic                     SC_RegSINK_zero_Out
`ifdef SC_REGSINK_CARRY_EN
  ,
  output logic                     SC_RegSINK_carry_Out
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state;
  logic [DATAWIDTH_BUS-1:0] data_q;
  logic [SHAMT_WIDTH-1:0]   cnt;
  logic                     dir_q;
  logic                     arith_q;
  logic                     busy_q;
  logic                     done_q;
  logic [DATAWIDTH_BUS-1:0] shifted;
  logic                     shout;

  // One-bit shift using the direction/fill latched at start.
  always_comb begin
    shifted = {data_q[DATAWIDTH_BUS-2:0], 1'b0};
    shout   = data_q[DATAWIDTH_BUS-1];
    if (dir_q) begin
      shifted = {arith_q & data_q[DATAWIDTH_BUS-1], data_q[DATAWIDTH_BUS-1:1]};
      shout   = data_q[0];
    end
  end

  always_ff @(posedge SC_RegFIXED_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
    if (SC_RegFIXED_RESET_InHigh) begin
      state   <= IDLE;
      data_q  <= DATA_REG_INIT;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (SC_RegSINK_clear_In) begin
      state  <= IDLE;
      data_q <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SC_RegSINK_load_In) begin
            data_q <= SC_RegSINK_data_InBUS;
          end else if (SC_RegSINK_start_In) begin
            if (|SC_RegSINK_shamt_In) begin
              state   <= SHIFT;
              cnt     <= SC_RegSINK_shamt_In;
              dir_q   <= SC_RegSINK_dir_In;
              arith_q <= SC_RegSINK_arith_In;
              busy_q  <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q <= shifted;
          cnt    <= cnt - 1'b1;
          if (cnt == SHAMT_WIDTH'(1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SC_REGSINK_CARRY_EN
  logic carry_q;

  always_ff @(posedge SC_RegFIXED_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
    if (SC_RegFIXED_RESET_InHigh)
      carry_q <= 1'b0;
    else if (SC_RegSINK_clear_In)
      carry_q <= 1'b0;
    else if (state == SHIFT)
      carry_q <= shout;
    else if (state == IDLE && SC_RegSINK_load_In)
      carry_q <= 1'b0;
  end

  assign SC_RegSINK_carry_Out = carry_q;
`else
  logic unused_shout;
  assign unused_shout = shout;
`endif

  assign SC_RegSINK_data_OutBUS = data_q;
  assign SC_RegSINK_zero_Out    = (data_q == '0);
  assign SC_RegSINK_busy_Out    = busy_q;
  assign SC_RegSINK_done_Out    = done_q;

endmodule

// File: tb/tb_sc_reg_shift_sink.sv
// Directed bench for sc_reg_shift_sink; carry checks compile in with SC_REGSINK_CARRY_EN.
module tb_sc_reg_shift_sink;
  localparam int W = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         load = 1'b0, clear = 1'b0, start = 1'b0, dir = 1'b0, arith = 1'b0;
  logic [S-1:0] shamt = '0;
  logic [W-1:0] dout;
  logic         busy, done, zero;
`ifdef SC_REGSINK_CARRY_EN
  logic         carry;
`endif

  int checks = 0;
  int errors = 0;

  sc_reg_shift_sink #(.DATAWIDTH_BUS(W), .DATA_REG_INIT(32'h000000A5), .SHAMT_WIDTH(S)) dut (
    .SC_RegFIXED_CLOCK_50    (clk),
    .SC_RegFIXED_RESET_InHigh(rst),
    .SC_RegSINK_data_InBUS   (din),
    .SC_RegSINK_load_In      (load),
    .SC_RegSINK_clear_In     (clear),
    .SC_RegSINK_start_In     (start),
    .SC_RegSINK_dir_In       (dir),
    .SC_RegSINK_arith_In     (arith),
    .SC_RegSINK_shamt_In     (shamt),
    .SC_RegSINK_data_OutBUS  (dout),
    .SC_RegSINK_busy_Out     (busy),
    .SC_RegSINK_done_Out     (done),
    .SC_RegSINK_zero_Out     (zero)
`ifdef SC_REGSINK_CARRY_EN
    ,
    .SC_RegSINK_carry_Out    (carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; din = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic d, input logic a, input logic [S-1:0] n);
    start = 1'b1; dir = d; arith = a; shamt = n;
    tick();
    start = 1'b0;
  endtask

  // Stimulus helper: counts busy cycles until the done pulse (bounded).
  task automatic wait_done(output int nb, output int nd);
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) begin nd++; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (dout !== 32'h000000A5) begin errors++; $display("FAIL reset_data got %h want %h", dout, 32'h000000A5); end
    checks++; if ({busy, done, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, zero}); end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (dout !== 32'h000000A5) begin errors++; $display("FAIL reset_hold got %h want %h", dout, 32'h000000A5); end
`ifdef SC_REGSINK_CARRY_EN
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry); end
`endif
  endtask

  task automatic test_load_clear();
    do_load(32'h12345678);
    checks++; if (dout !== 32'h12345678) begin errors++; $display("FAIL load_data got %h want 12345678", dout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done got %b want 0", done); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (dout !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL clear got %h zero %b want 0 zero 1", dout, zero); end
  endtask

  task automatic test_shift_left();
    int nb, nd;
    do_load(32'h0000000F);
    do_start(1'b0, 1'b0, 5'd4);
    wait_done(nb, nd);
    checks++; if (nb !== 4) begin errors++; $display("FAIL shl_busy_cycles got %0d want 4", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL shl_done got %0d want 1", nd); end
    checks++; if (dout !== 32'h000000F0) begin errors++; $display("FAIL shl_data got %h want 000000F0", dout); end
`ifdef SC_REGSINK_CARRY_EN
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL shl_carry got %b want 0", carry); end
`endif
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL shl_idle got %b want 00", {busy, done}); end
  endtask

  task automatic test_shift_right();
    int nb, nd;
    do_load(32'h80000001);
    do_start(1'b1, 1'b1, 5'd8);
    dir = 1'b0; arith = 1'b0; shamt = 5'd1;  // must not affect the running shift
    wait_done(nb, nd);
    checks++; if (nb !== 8 || nd !== 1) begin errors++; $display("FAIL sra_timing got busy %0d done %0d want 8 1", nb, nd); end
    checks++; if (dout !== 32'hFF800000) begin errors++; $display("FAIL sra_data got %h want FF800000", dout); end
`ifdef SC_REGSINK_CARRY_EN
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sra_carry got %b want 0", carry); end
`endif
    tick();
    do_load(32'h80000001);
    do_start(1'b1, 1'b0, 5'd8);
    wait_done(nb, nd);
    checks++; if (dout !== 32'h00800000 || nd !== 1) begin errors++; $display("FAIL srl_data got %h done %0d want 00800000 1", dout, nd); end
    tick();
    // Right shift by 1 of an odd value: carry must capture bit 0
    do_load(32'h00000003);
    do_start(1'b1, 1'b0, 5'd1);
    wait_done(nb, nd);
    checks++; if (dout !== 32'h00000001 || nb !== 1) begin errors++; $display("FAIL srl1 got %h busy %0d want 00000001 1", dout, nb); end
`ifdef SC_REGSINK_CARRY_EN
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL srl1_carry got %b want 1", carry); end
`endif
    tick();
  endtask

  task automatic test_shamt_zero();
    do_load(32'hDEADBEEF);
    do_start(1'b0, 1'b0, 5'd0);
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL sh0_flags got %b want 01", {busy, done}); end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL sh0_data got %h want DEADBEEF", dout); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL sh0_after got %b want 00", {busy, done}); end
  endtask

  task automatic test_load_beats_start();
    load = 1'b1; din = 32'h00000005; start = 1'b1; shamt = 5'd3; dir = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    checks++; if (dout !== 32'h5 || busy !== 1'b0) begin errors++; $display("FAIL ld_start got %h busy %b want 5 0", dout, busy); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ld_start_after got %b want 00", {busy, done}); end
  endtask

  task automatic test_abort();
    int nb, nd;
    do_load(32'h00000001);
    do_start(1'b0, 1'b0, 5'd6);
    load = 1'b1; din = 32'hFFFFFFFF;   // SHIFT cycle 1
    tick();
    load = 1'b0;
    checks++; if (dout !== 32'h2 || busy !== 1'b1) begin errors++; $display("FAIL abort_ld_ignored got %h busy %b want 2 1", dout, busy); end
    tick();                            // SHIFT cycle 3 begins
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (dout !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL abort_clear got %h zero %b want 0 1", dout, zero); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_flags got %b want 00", {busy, done}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", done); end
    do_load(32'h00000003);
    do_start(1'b0, 1'b0, 5'd2);
    wait_done(nb, nd);
    checks++; if (dout !== 32'hC || nb !== 2 || nd !== 1) begin errors++; $display("FAIL restart got %h busy %0d done %0d want C 2 1", dout, nb, nd); end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    do_load(32'h00000001);
    do_start(1'b0, 1'b0, 5'd10);
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (dout !== 32'h000000A5 || {busy, done} !== 2'b00) begin errors++; $display("FAIL rst_mid got %h flags %b want A5 00", dout, {busy, done}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({busy, done} !== 2'b00 || dout !== 32'h000000A5) begin errors++; $display("FAIL rst_mid_after got %h flags %b want A5 00", dout, {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_load_clear();
    test_shift_left();
    test_shift_right();
    test_shamt_zero();
    test_load_beats_start();
    test_abort();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
